// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer
// Front end for a separate 16-bit combinational ALU. It holds an 8 x 16 register
// file, accepts register loads and register-to-register instructions over
// valid/ready handshakes, and sequences each instruction through three cycles:
// accept (IDLE), ALU evaluation (EXEC) and writeback (WB).
// R0 is hard-wired to zero. Loads take priority over instructions.

module alu_issue_sequencer #(
    parameter int DW   = 16,
    parameter int NREG = 8,
    localparam int AW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,

    // Register-load channel
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,

    // Instruction channel
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    instr_op,
    input  logic [AW-1:0] instr_rd,
    input  logic [AW-1:0] instr_rs1,
    input  logic [AW-1:0] instr_rs2,
    input  logic          instr_cin,

    // Connection to the external ALU
    output logic [DW-1:0] alu_A,
    output logic [DW-1:0] alu_B,
    output logic          alu_C,
    output logic [2:0]    alu_operator,
    input  logic [DW-1:0] alu_W,
    input  logic          alu_zero,
    input  logic          alu_neg,

    // Completion and status
    output logic          done,
    output logic [DW-1:0] done_result,
    output logic          flag_zero,
    output logic          flag_neg,

    // Debug read port
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    // Operator code that selects add-with-carry; the only op that sees carry-in.
    localparam logic [2:0] OP_ADDC = 3'b010;
    // Operator code driven to the ALU whenever no instruction is executing.
    localparam logic [2:0] OP_IDLE = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WB
    } state_t;

    state_t state_q, state_d;

    // Register file storage
    logic [DW-1:0] regfile_q [NREG];

    // Latched instruction fields and operands
    logic [DW-1:0] opA_q, opA_d;
    logic [DW-1:0] opB_q, opB_d;
    logic [2:0]    op_q, op_d;
    logic [AW-1:0] rd_q, rd_d;
    logic          cin_q, cin_d;

    // Captured ALU result and flags, pending writeback
    logic [DW-1:0] res_q, res_d;
    logic          z_q, z_d;
    logic          n_q, n_d;

    // Architectural status of the last completed instruction
    logic [DW-1:0] doneResult_q, doneResult_d;
    logic          flagZero_q, flagZero_d;
    logic          flagNeg_q, flagNeg_d;

    // Single register-file write port shared by loads and writeback
    logic          rfWe;
    logic [AW-1:0] rfWaddr;
    logic [DW-1:0] rfWdata;

    // Combinational source reads; R0 is forced to zero on every read port
    logic [DW-1:0] rs1Data;
    logic [DW-1:0] rs2Data;

    assign rs1Data  = (instr_rs1 == '0) ? '0 : regfile_q[instr_rs1];
    assign rs2Data  = (instr_rs2 == '0) ? '0 : regfile_q[instr_rs2];
    assign dbg_data = (dbg_addr  == '0) ? '0 : regfile_q[dbg_addr];

    assign done_result = doneResult_q;
    assign flag_zero   = flagZero_q;
    assign flag_neg    = flagNeg_q;

    // Next-state, handshake, ALU-drive and writeback decode for the issue FSM
    always_comb begin
        state_d      = state_q;
        opA_d        = opA_q;
        opB_d        = opB_q;
        op_d         = op_q;
        rd_d         = rd_q;
        cin_d        = cin_q;
        res_d        = res_q;
        z_d          = z_q;
        n_d          = n_q;
        doneResult_d = doneResult_q;
        flagZero_d   = flagZero_q;
        flagNeg_d    = flagNeg_q;
        rfWe         = 1'b0;
        rfWaddr      = ld_addr;
        rfWdata      = ld_data;
        ld_ready     = 1'b0;
        instr_ready  = 1'b0;
        done         = 1'b0;
        alu_A        = '0;
        alu_B        = '0;
        alu_C        = 1'b0;
        alu_operator = OP_IDLE;

        case (state_q)
            IDLE: begin
                ld_ready    = rst_n;
                instr_ready = rst_n & ~ld_valid;
                if (ld_valid) begin
                    rfWe    = (ld_addr != '0);
                    rfWaddr = ld_addr;
                    rfWdata = ld_data;
                end else if (instr_valid) begin
                    opA_d   = rs1Data;
                    opB_d   = rs2Data;
                    op_d    = instr_op;
                    rd_d    = instr_rd;
                    cin_d   = instr_cin;
                    state_d = EXEC;
                end
            end

            EXEC: begin
                alu_A        = opA_q;
                alu_B        = opB_q;
                alu_operator = op_q;
                alu_C        = (op_q == OP_ADDC) ? cin_q : 1'b0;
                res_d        = alu_W;
                z_d          = alu_zero;
                n_d          = alu_neg;
                state_d      = WB;
            end

            WB: begin
                done         = rst_n;
                rfWe         = (rd_q != '0);
                rfWaddr      = rd_q;
                rfWdata      = res_q;
                doneResult_d = res_q;
                flagZero_d   = z_q;
                flagNeg_d    = n_q;
                state_d      = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand, result and status registers; reset abandons any instruction in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            opA_q        <= '0;
            opB_q        <= '0;
            op_q         <= '0;
            rd_q         <= '0;
            cin_q        <= 1'b0;
            res_q        <= '0;
            z_q          <= 1'b0;
            n_q          <= 1'b0;
            doneResult_q <= '0;
            flagZero_q   <= 1'b0;
            flagNeg_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            opA_q        <= opA_d;
            opB_q        <= opB_d;
            op_q         <= op_d;
            rd_q         <= rd_d;
            cin_q        <= cin_d;
            res_q        <= res_d;
            z_q          <= z_d;
            n_q          <= n_d;
            doneResult_q <= doneResult_d;
            flagZero_q   <= flagZero_d;
            flagNeg_q    <= flagNeg_d;
        end
    end

    // Register file: cleared on reset, otherwise one write per cycle from load or writeback
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regfile_q[i] <= '0;
            end
        end else if (rfWe) begin
            regfile_q[rfWaddr] <= rfWdata;
        end
    end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Testbench for alu_issue_sequencer.
// A behavioural stand-in for the 16-bit ALU answers the DUT's alu_* outputs.
// A register-file model and a scoreboard queue predict every completed result.

module tb_alu_issue_sequencer;

    logic        clk;
    logic        rst_n;
    logic        ld_valid;
    logic        ld_ready;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  instr_op;
    logic [2:0]  instr_rd;
    logic [2:0]  instr_rs1;
    logic [2:0]  instr_rs2;
    logic        instr_cin;
    logic [15:0] alu_A;
    logic [15:0] alu_B;
    logic        alu_C;
    logic [2:0]  alu_operator;
    logic [15:0] alu_W;
    logic        alu_zero;
    logic        alu_neg;
    logic        done;
    logic [15:0] done_result;
    logic        flag_zero;
    logic        flag_neg;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] res;
    } exp_t;

    exp_t        sbQ[$];
    logic [15:0] model [8];
    int          vectors;
    int          miscompares;
    int          cycleCnt;
    int          acc1;
    int          acc2;
    int          accDummy;

    alu_issue_sequencer #(.DW(16), .NREG(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_rd     (instr_rd),
        .instr_rs1    (instr_rs1),
        .instr_rs2    (instr_rs2),
        .instr_cin    (instr_cin),
        .alu_A        (alu_A),
        .alu_B        (alu_B),
        .alu_C        (alu_C),
        .alu_operator (alu_operator),
        .alu_W        (alu_W),
        .alu_zero     (alu_zero),
        .alu_neg      (alu_neg),
        .done         (done),
        .done_result  (done_result),
        .flag_zero    (flag_zero),
        .flag_neg     (flag_neg),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    // Stand-in ALU: 000 negate, 010 add with carry, 101 OR, 110 XNOR, 111 zero
    function automatic logic [15:0] aluModel(input logic [2:0] op, input logic [15:0] a,
                                             input logic [15:0] b, input logic c);
        case (op)
            3'b000:  return 16'd0 - a;
            3'b001:  return a - b;
            3'b010:  return a + b + {15'd0, c};
            3'b011:  return a & b;
            3'b100:  return a ^ b;
            3'b101:  return a | b;
            3'b110:  return ~(a ^ b);
            default: return 16'h0000;
        endcase
    endfunction

    assign alu_W    = aluModel(alu_operator, alu_A, alu_B, alu_C);
    assign alu_zero = (alu_W == 16'h0000);
    assign alu_neg  = alu_W[15];

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to measure latency and accept spacing
    initial cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Hard stop in case something wedges outside a bounded wait
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic loadReg(input logic [2:0] addr, input logic [15:0] data);
        int n;
        ld_addr  = addr;
        ld_data  = data;
        ld_valid = 1'b1;
        #1;
        n = 0;
        while (!ld_ready && n < 20) begin
            nextCycle();
            #1;
            n++;
        end
        checkOutput("ld_ready", {15'd0, ld_ready}, 16'd1);
        nextCycle();
        ld_valid = 1'b0;
        if (addr != 3'd0) model[addr] = data;
        dbg_addr = addr;
        #1;
        checkOutput("ld_dbg", dbg_data, model[addr]);
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                                 input logic [2:0] rs2, input logic cin, input logic hold,
                                 output int acceptCycle);
        int   n;
        exp_t e;
        logic expC;
        instr_op    = op;
        instr_rd    = rd;
        instr_rs1   = rs1;
        instr_rs2   = rs2;
        instr_cin   = cin;
        instr_valid = 1'b1;
        #1;
        n = 0;
        while (!instr_ready && n < 20) begin
            nextCycle();
            #1;
            n++;
        end
        checkOutput("accept_ready", {15'd0, instr_ready}, 16'd1);
        acceptCycle = cycleCnt;
        expC  = (op == 3'b010) ? cin : 1'b0;
        e.rd  = rd;
        e.res = aluModel(op, model[rs1], model[rs2], expC);
        sbQ.push_back(e);

        nextCycle();
        if (!hold) instr_valid = 1'b0;
        #1;
        checkOutput("exec_op", {13'd0, alu_operator}, {13'd0, op});
        checkOutput("exec_A", alu_A, model[rs1]);
        checkOutput("exec_B", alu_B, model[rs2]);
        checkOutput("exec_C", {15'd0, alu_C}, {15'd0, expC});
        checkOutput("exec_irdy", {15'd0, instr_ready}, 16'd0);
        checkOutput("exec_done", {15'd0, done}, 16'd0);

        nextCycle();
        #1;
        checkOutput("wb_done", {15'd0, done}, 16'd1);
        checkOutput("done_latency", 16'(cycleCnt - acceptCycle), 16'd2);
        checkOutput("wb_ldrdy", {15'd0, ld_ready}, 16'd0);

        nextCycle();
        #1;
        checkOutput("done_pulse", {15'd0, done}, 16'd0);
        checkOutput("sb_nonempty", 16'(sbQ.size()), 16'd1);
        if (sbQ.size() != 0) begin
            e = sbQ.pop_front();
            checkOutput("done_result", done_result, e.res);
            checkOutput("flag_zero", {15'd0, flag_zero}, {15'd0, e.res == 16'h0000});
            checkOutput("flag_neg", {15'd0, flag_neg}, {15'd0, e.res[15]});
            if (e.rd != 3'd0) model[e.rd] = e.res;
            dbg_addr = e.rd;
            #1;
            checkOutput("wb_dbg", dbg_data, model[e.rd]);
        end
    endtask

    task automatic checkAllZero(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            checkOutput(tag, dbg_data, 16'h0000);
            checkOutput("no_done", {15'd0, done}, 16'd0);
            nextCycle();
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        ld_valid    = 1'b0;
        ld_addr     = 3'd0;
        ld_data     = 16'h0000;
        instr_valid = 1'b0;
        instr_op    = 3'd0;
        instr_rd    = 3'd0;
        instr_rs1   = 3'd0;
        instr_rs2   = 3'd0;
        instr_cin   = 1'b0;
        dbg_addr    = 3'd0;
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;

        // Reset: ready held low while rst_n is low, clean state afterwards
        nextCycle();
        ld_valid = 1'b1;
        #1;
        checkOutput("rst_ldrdy", {15'd0, ld_ready}, 16'd0);
        checkOutput("rst_irdy", {15'd0, instr_ready}, 16'd0);
        ld_valid = 1'b0;
        nextCycle();
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_irdy", {15'd0, instr_ready}, 16'd1);
        checkOutput("idle_alu_op", {13'd0, alu_operator}, 16'd7);
        checkOutput("idle_alu_A", alu_A, 16'h0000);
        checkOutput("rst_done_result", done_result, 16'h0000);
        checkOutput("rst_flags", {14'd0, flag_zero, flag_neg}, 16'd0);
        checkAllZero("rst_reg");

        // Add with carry: 5 + 3 + 1
        loadReg(3'd1, 16'd5);
        loadReg(3'd2, 16'd3);
        applyStimulus(3'b010, 3'd3, 3'd1, 3'd2, 1'b1, 1'b0, accDummy);
        checkOutput("addc_const", done_result, 16'd9);

        // Negate R1; carry-in must not reach the ALU
        applyStimulus(3'b000, 3'd4, 3'd1, 3'd0, 1'b1, 1'b0, accDummy);
        checkOutput("neg_const", done_result, 16'hFFFB);
        checkOutput("neg_flag", {15'd0, flag_neg}, 16'd1);

        // R0 discards writes; op 111 yields zero
        loadReg(3'd0, 16'h1234);
        applyStimulus(3'b111, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, accDummy);
        checkOutput("op7_zflag", {15'd0, flag_zero}, 16'd1);
        checkOutput("op7_r0", dbg_data, 16'h0000);

        // Dependent back-to-back with instr_valid held
        loadReg(3'd1, 16'h00F0);
        loadReg(3'd2, 16'h0F0F);
        applyStimulus(3'b101, 3'd5, 3'd1, 3'd2, 1'b0, 1'b1, acc1);
        applyStimulus(3'b110, 3'd6, 3'd5, 3'd2, 1'b0, 1'b0, acc2);
        checkOutput("b2b_spacing", 16'(acc2 - acc1), 16'd3);
        checkOutput("b2b_const", done_result, 16'hFF0F);

        // Load and instruction together: load wins, instruction uses new value
        instr_op    = 3'b010;
        instr_rd    = 3'd7;
        instr_rs1   = 3'd1;
        instr_rs2   = 3'd1;
        instr_cin   = 1'b0;
        instr_valid = 1'b1;
        ld_addr     = 3'd1;
        ld_data     = 16'h0007;
        ld_valid    = 1'b1;
        #1;
        checkOutput("contend_irdy", {15'd0, instr_ready}, 16'd0);
        loadReg(3'd1, 16'h0007);
        applyStimulus(3'b010, 3'd7, 3'd1, 3'd1, 1'b0, 1'b0, accDummy);
        checkOutput("contend_const", done_result, 16'd14);

        // Reset during EXEC abandons the instruction and clears everything
        instr_op    = 3'b010;
        instr_rd    = 3'd3;
        instr_rs1   = 3'd1;
        instr_rs2   = 3'd2;
        instr_cin   = 1'b0;
        instr_valid = 1'b1;
        #1;
        checkOutput("midrst_accept", {15'd0, instr_ready}, 16'd1);
        nextCycle();
        instr_valid = 1'b0;
        rst_n       = 1'b0;
        #1;
        checkOutput("midrst_ldrdy", {15'd0, ld_ready}, 16'd0);
        checkOutput("midrst_done", {15'd0, done}, 16'd0);
        nextCycle();
        rst_n = 1'b1;
        #1;
        checkOutput("midrst_irdy", {15'd0, instr_ready}, 16'd1);
        checkOutput("midrst_result", done_result, 16'h0000);
        checkOutput("midrst_flags", {14'd0, flag_zero, flag_neg}, 16'd0);
        checkOutput("midrst_alu_A", alu_A, 16'h0000);
        checkOutput("midrst_alu_op", {13'd0, alu_operator}, 16'd7);
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        sbQ.delete();
        checkAllZero("midrst_reg");

        // Normal operation resumes after reset
        loadReg(3'd2, 16'h8000);
        applyStimulus(3'b010, 3'd1, 3'd2, 3'd2, 1'b0, 1'b0, accDummy);
        checkOutput("resume_zflag", {15'd0, flag_zero}, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
